// File: rtl/transferreg_ctrl.sv
// Transfer-register sequencer: turns one handshaken command at a time into
// ordered LOAD_*/LOAD_SELECT strobes and grant-gated ASSERT_*_bar enables.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a command; NOP/reserved complete here
// SETUP    | LOAD_SELECT driven, strobes low
// STROBE   | selected load strobe(s) high
// HOLD     | strobes fall (capture edge), LOAD_SELECT held, DONE
// WAIT_GNT | waiting for the bus grant that matches the assert command
// DRIVE    | one ASSERT_*_bar low, down-counting the drive length
module transferreg_ctrl #(
   parameter int DRIVE_CYCLES = 1,
   parameter int DELAY_RISE   = 0,
   parameter int DELAY_FALL   = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [2:0] CMD,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic       MAIN_GNT,
   input  logic       ADDR_GNT,
   output logic       LOAD_LOW,
   output logic       LOAD_HIGH,
   output logic       LOAD_SELECT,
   output logic       ASSERT_LOW_bar,
   output logic       ASSERT_HIGH_bar,
   output logic       ASSERT_ADDR_bar,
   output logic       DONE,
   output logic       ERR
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAIT_GNT, S_DRIVE
   } state_t;

   localparam logic [2:0] C_NOP         = 3'd0;
   localparam logic [2:0] C_LOAD_ADDR   = 3'd1;
   localparam logic [2:0] C_LOAD_LOW    = 3'd2;
   localparam logic [2:0] C_LOAD_HIGH   = 3'd3;
   localparam logic [2:0] C_ASSERT_LOW  = 3'd4;
   localparam logic [2:0] C_ASSERT_HIGH = 3'd5;
   localparam logic [2:0] C_ASSERT_ADDR = 3'd6;
   localparam logic [2:0] C_RSVD        = 3'd7;

   // A zero drive length would never reach terminal count, so it runs as one cycle.
   localparam logic [3:0] DRV_N = (DRIVE_CYCLES <= 0) ? 4'd1 : 4'(DRIVE_CYCLES);

   // Edge delays only matter to back-annotated timing models; the zero-delay RTL has no use for them.
   if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_timing_model_only
   end

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic [2:0] cmd_q, cmd_nx;
   logic       accept, gnt;
   logic       ready_nx, load_low_nx, load_high_nx, select_nx;
   logic       a_low_bar_nx, a_high_bar_nx, a_addr_bar_nx, done_nx, err_nx;

   assign accept = CMD_VALID && (state == S_IDLE);
   assign gnt    = (cmd_q == C_ASSERT_ADDR) ? ADDR_GNT : MAIN_GNT;

   // State, drive counter, latched command and all output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state           <= S_IDLE;
         cnt             <= 4'd0;
         cmd_q           <= C_NOP;
         CMD_READY       <= 1'b1;
         LOAD_LOW        <= 1'b0;
         LOAD_HIGH       <= 1'b0;
         LOAD_SELECT     <= 1'b0;
         ASSERT_LOW_bar  <= 1'b1;
         ASSERT_HIGH_bar <= 1'b1;
         ASSERT_ADDR_bar <= 1'b1;
         DONE            <= 1'b0;
         ERR             <= 1'b0;
      end else begin
         state           <= state_nx;
         cnt             <= cnt_nx;
         cmd_q           <= cmd_nx;
         CMD_READY       <= ready_nx;
         LOAD_LOW        <= load_low_nx;
         LOAD_HIGH       <= load_high_nx;
         LOAD_SELECT     <= select_nx;
         ASSERT_LOW_bar  <= a_low_bar_nx;
         ASSERT_HIGH_bar <= a_high_bar_nx;
         ASSERT_ADDR_bar <= a_addr_bar_nx;
         DONE            <= done_nx;
         ERR             <= err_nx;
      end
   end

   // Next state: command dispatch, load sequence, grant wait and drive count.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cmd_nx   = cmd_q;
      case (state)
         S_IDLE: begin
            if (accept) begin
               cmd_nx = CMD;
               case (CMD)
                  C_LOAD_ADDR, C_LOAD_LOW, C_LOAD_HIGH:        state_nx = S_SETUP;
                  C_ASSERT_LOW, C_ASSERT_HIGH, C_ASSERT_ADDR:  state_nx = S_WAIT_GNT;
                  default:                                     state_nx = S_IDLE;
               endcase
            end
         end
         S_SETUP:  state_nx = S_STROBE;
         S_STROBE: state_nx = S_HOLD;
         S_HOLD:   state_nx = S_IDLE;
         S_WAIT_GNT: begin
            if (gnt) begin
               state_nx = S_DRIVE;
               cnt_nx   = DRV_N;
            end
         end
         S_DRIVE: begin
            if (cnt == 4'd1) state_nx = S_IDLE;
            else             cnt_nx   = cnt - 4'd1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Output values for the coming cycle, decoded from the next state so every pin leaves a flop.
   always_comb begin
      ready_nx      = (state_nx == S_IDLE);
      load_low_nx   = (state_nx == S_STROBE) && (cmd_nx == C_LOAD_ADDR || cmd_nx == C_LOAD_LOW);
      load_high_nx  = (state_nx == S_STROBE) && (cmd_nx == C_LOAD_ADDR || cmd_nx == C_LOAD_HIGH);
      select_nx     = LOAD_SELECT;
      if (state_nx == S_SETUP) select_nx = (cmd_nx != C_LOAD_ADDR);
      a_low_bar_nx  = !((state_nx == S_DRIVE) && (cmd_nx == C_ASSERT_LOW));
      a_high_bar_nx = !((state_nx == S_DRIVE) && (cmd_nx == C_ASSERT_HIGH));
      a_addr_bar_nx = !((state_nx == S_DRIVE) && (cmd_nx == C_ASSERT_ADDR));
      done_nx       = (state_nx == S_HOLD)
                   || ((state_nx == S_DRIVE) && (cnt_nx == 4'd1))
                   || (accept && (CMD == C_NOP || CMD == C_RSVD));
      err_nx        = accept && (CMD == C_RSVD);
   end

endmodule
